// File: rtl/fpga_cfg_loader_pkg.sv
// fpga_cfg_pkg: types and helpers shared by the configuration loader and
// the fpga wrapper generation flow.
//   cfg_state_e        loader FSM state encoding
//   onehot_bit()       one bit of a one-hot group select
//   DEFAULT_CFG_WIDTH  default configs_in width of the generated fabric
//   DEFAULT_NUM_GROUPS default number of configuration groups
package fpga_cfg_pkg;

    localparam int DEFAULT_CFG_WIDTH  = 320;
    localparam int DEFAULT_NUM_GROUPS = 172;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_LOAD,
        ST_STROBE,
        ST_POST,
        ST_FFW,
        ST_DONE,
        ST_ERR
    } cfg_state_e;

    // The decoder is built one bit at a time so that the group count can be
    // any loader parameter without a fixed-width intermediate vector.
    function automatic logic onehot_bit(input int sel, input int pos);
        return sel == pos;
    endfunction

endpackage

// File: rtl/fpga_cfg_loader_if.sv
// fpga_cfg_loader_if: valid/ready word stream from the host/scan port into
// the configuration loader.
//   cfg_valid  host -> loader  word present on cfg_data
//   cfg_data   host -> loader  configuration word (CFG_WIDTH)
//   cfg_last   host -> loader  marks final word of the bitstream
//   cfg_ready  loader -> host  loader accepts a word this cycle
// Modports: master (host side), slave (loader side).
interface fpga_cfg_loader_if import fpga_cfg_pkg::*; #(
    parameter int CFG_WIDTH = DEFAULT_CFG_WIDTH
) ();

    logic                 cfg_valid;
    logic [CFG_WIDTH-1:0] cfg_data;
    logic                 cfg_last;
    logic                 cfg_ready;

    modport master (output cfg_valid, cfg_data, cfg_last, input cfg_ready);
    modport slave  (input cfg_valid, cfg_data, cfg_last, output cfg_ready);

endinterface

// File: rtl/fpga_cfg_loader_delay_cnt.sv
// cfg_delay_cnt: loadable down-counter used for the PRE, POST and FFW waits.
//   clock, rst_n  clock and asynchronous active-low reset
//   load          load load_val this cycle (wins over counting)
//   load_val      wait length in cycles, must be >= 1
//   done          high during the last cycle of the loaded wait
// After a load of N, done is high in the N-th cycle following the load edge;
// the counter then parks at zero, so done pulses once per load.
module cfg_delay_cnt #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: streams configuration words into the fabric one group at
// a time, then releases ff_en and rdy after programmable settle delays.
//   clock, rst_n  clock and asynchronous active-low reset
//   start         1-cycle pulse, begins or restarts a load from any state
//   cfg           word stream (slave side of fpga_cfg_loader_if)
//   configs_in    registered word driven to the fabric
//   configs_en    one-hot group write enable
//   ff_en         fabric flip-flop enable
//   rdy           configuration complete, fabric live
//   busy          load in progress (not IDLE/DONE/ERR)
//   err           sticky word-count error, cleared by start
// The interface instance must be built with the same CFG_WIDTH.
module fpga_cfg_loader import fpga_cfg_pkg::*; #(
    parameter int CFG_WIDTH     = DEFAULT_CFG_WIDTH,
    parameter int NUM_GROUPS    = DEFAULT_NUM_GROUPS,
    parameter int PRE_WAIT      = 10,
    parameter int POST_WAIT     = 10,
    parameter int FF_DELAY      = 10,
    parameter int ALLOW_PARTIAL = 0
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  start,
    fpga_cfg_loader_if.slave      cfg,
    output logic [CFG_WIDTH-1:0]  configs_in,
    output logic [NUM_GROUPS-1:0] configs_en,
    output logic                  ff_en,
    output logic                  rdy,
    output logic                  busy,
    output logic                  err
);

    localparam int IDX_W    = $clog2(NUM_GROUPS + 1);
    localparam int MAX_WAIT = (PRE_WAIT > POST_WAIT)
                            ? ((PRE_WAIT  > FF_DELAY) ? PRE_WAIT  : FF_DELAY)
                            : ((POST_WAIT > FF_DELAY) ? POST_WAIT : FF_DELAY);
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [IDX_W-1:0] GRP_CNT = IDX_W'(NUM_GROUPS);

    cfg_state_e            state;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_inc;
    logic                  last_q;
    logic                  cfg_ready_q;
    logic                  accept;
    logic                  grp_full;
    logic                  to_post;
    logic                  to_err;
    logic [NUM_GROUPS-1:0] oh_cur;
    logic [NUM_GROUPS-1:0] oh_nxt;
    logic                  cnt_load;
    logic [CNT_W-1:0]      cnt_val;
    logic                  cnt_done;

    assign cfg.cfg_ready = cfg_ready_q;
    assign accept        = cfg_ready_q && cfg.cfg_valid;
    assign idx_inc       = idx + IDX_W'(1);
    assign grp_full      = (idx_inc == GRP_CNT);

    always_comb begin
        oh_cur = '0;
        oh_nxt = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            oh_cur[g] = onehot_bit(32'(idx), g);
            oh_nxt[g] = onehot_bit(32'(idx_inc), g);
        end
    end

    // Exit decision for the strobe cycle; last_q only exists when a word was
    // actually accepted, so a stray cfg_last without cfg_valid never counts.
    always_comb begin
        to_post = 1'b0;
        to_err  = 1'b0;
        if (state == ST_STROBE) begin
            if (last_q) begin
                if (grp_full || (ALLOW_PARTIAL != 0)) to_post = 1'b1;
                else                                  to_err  = 1'b1;
            end else if (grp_full) begin
                to_err = 1'b1;
            end
        end
    end

    // The counter is loaded on the same edge the FSM enters the waiting
    // state, so each wait lasts exactly its programmed number of cycles.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        if (start) begin
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(PRE_WAIT);
        end else if (to_post) begin
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(POST_WAIT);
        end else if (state == ST_POST && cnt_done) begin
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(FF_DELAY);
        end
    end

    cfg_delay_cnt #(.W(CNT_W)) u_delay (
        .clock    (clock),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            last_q      <= 1'b0;
            cfg_ready_q <= 1'b0;
            configs_in  <= '0;
            configs_en  <= '0;
            ff_en       <= 1'b0;
            rdy         <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else if (start) begin
            // Restart from any state; a word offered this cycle is dropped.
            state       <= ST_PRE;
            idx         <= '0;
            last_q      <= 1'b0;
            cfg_ready_q <= 1'b0;
            configs_en  <= '0;
            ff_en       <= 1'b0;
            rdy         <= 1'b0;
            busy        <= 1'b1;
            err         <= 1'b0;
        end else begin
            case (state)
                ST_PRE: begin
                    if (cnt_done) begin
                        state       <= ST_LOAD;
                        cfg_ready_q <= 1'b1;
                        configs_en  <= oh_cur;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        state       <= ST_STROBE;
                        cfg_ready_q <= 1'b0;
                        configs_in  <= cfg.cfg_data;
                        last_q      <= cfg.cfg_last;
                    end
                end
                ST_STROBE: begin
                    // configs_en is held through this cycle so the fabric
                    // latches the word now on configs_in.
                    idx <= idx_inc;
                    if (to_post) begin
                        state      <= ST_POST;
                        configs_en <= '0;
                    end else if (to_err) begin
                        state      <= ST_ERR;
                        configs_en <= '0;
                        busy       <= 1'b0;
                        err        <= 1'b1;
                    end else begin
                        state       <= ST_LOAD;
                        cfg_ready_q <= 1'b1;
                        configs_en  <= oh_nxt;
                    end
                end
                ST_POST: begin
                    if (cnt_done) begin
                        state <= ST_FFW;
                        ff_en <= 1'b1;
                    end
                end
                ST_FFW: begin
                    if (cnt_done) begin
                        state <= ST_DONE;
                        rdy   <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    // IDLE, DONE and ERR hold until the next start.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed bench for fpga_cfg_loader: NUM_GROUPS=4, all waits 2 cycles.
// dut0 (ALLOW_PARTIAL=0) and dut1 (ALLOW_PARTIAL=1) receive the same stream.
module tb_fpga_cfg_loader;

    localparam int CW = 16;
    localparam int NG = 4;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          valid = 1'b0;
    logic [CW-1:0] data  = '0;
    logic          last  = 1'b0;

    logic [CW-1:0] cin0, cin1;
    logic [NG-1:0] cen0, cen1;
    logic          ffen0, ffen1, rdy0, rdy1, busy0, busy1, err0, err1;

    logic [CW-1:0] words [4];
    int errors = 0;
    int checks = 0;

    fpga_cfg_loader_if #(.CFG_WIDTH(CW)) bus0 ();
    fpga_cfg_loader_if #(.CFG_WIDTH(CW)) bus1 ();

    assign bus0.cfg_valid = valid;
    assign bus0.cfg_data  = data;
    assign bus0.cfg_last  = last;
    assign bus1.cfg_valid = valid;
    assign bus1.cfg_data  = data;
    assign bus1.cfg_last  = last;

    fpga_cfg_loader #(.CFG_WIDTH(CW), .NUM_GROUPS(NG), .PRE_WAIT(2), .POST_WAIT(2),
                      .FF_DELAY(2), .ALLOW_PARTIAL(0)) dut0 (
        .clock(clock), .rst_n(rst_n), .start(start), .cfg(bus0),
        .configs_in(cin0), .configs_en(cen0), .ff_en(ffen0), .rdy(rdy0),
        .busy(busy0), .err(err0));

    fpga_cfg_loader #(.CFG_WIDTH(CW), .NUM_GROUPS(NG), .PRE_WAIT(2), .POST_WAIT(2),
                      .FF_DELAY(2), .ALLOW_PARTIAL(1)) dut1 (
        .clock(clock), .rst_n(rst_n), .start(start), .cfg(bus1),
        .configs_in(cin1), .configs_en(cen1), .ff_en(ffen1), .rdy(rdy1),
        .busy(busy1), .err(err1));

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({bus0.cfg_ready, cin0, cen0, ffen0, rdy0, busy0, err0} !== '0) begin
            errors++; $display("FAIL reset_dut0: got %b/%h/%b/%b%b%b%b want all zero",
                bus0.cfg_ready, cin0, cen0, ffen0, rdy0, busy0, err0);
        end
        checks++;
        if ({bus1.cfg_ready, cin1, cen1, ffen1, rdy1, busy1, err1} !== '0) begin
            errors++; $display("FAIL reset_dut1: got nonzero outputs, want all zero");
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        do_start();
        checks++;
        if (busy0 !== 1'b1 || bus0.cfg_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_pre: busy=%b ready=%b want 1 0", busy0, bus0.cfg_ready);
        end
        step(); step();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus0.cfg_ready !== 1'b1 || cen0 !== 4'(1 << k)) begin
                errors++; $display("FAIL b2b_load%0d: ready=%b en=%b want 1 %b", k, bus0.cfg_ready, cen0, 4'(1 << k));
            end
            valid = 1'b1; data = words[k]; last = (k == 3);
            step();
            checks++;
            if (cin0 !== words[k] || cen0 !== 4'(1 << k) || bus0.cfg_ready !== 1'b0) begin
                errors++; $display("FAIL b2b_strobe%0d: in=%h en=%b ready=%b want %h %b 0", k, cin0, cen0, bus0.cfg_ready, words[k], 4'(1 << k));
            end
            if (k != 3) step();
        end
        valid = 1'b0; last = 1'b0;
        step();
        checks++;
        if (cen0 !== 4'b0000 || ffen0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++; $display("FAIL b2b_post: en=%b ff_en=%b busy=%b want 0000 0 1", cen0, ffen0, busy0);
        end
        step();
        checks++;
        if (ffen0 !== 1'b0) begin
            errors++; $display("FAIL b2b_post2: ff_en=%b want 0", ffen0);
        end
        step();
        checks++;
        if (ffen0 !== 1'b1 || rdy0 !== 1'b0) begin
            errors++; $display("FAIL b2b_ffen: ff_en=%b rdy=%b want 1 0", ffen0, rdy0);
        end
        step();
        checks++;
        if (rdy0 !== 1'b0) begin
            errors++; $display("FAIL b2b_ffw2: rdy=%b want 0", rdy0);
        end
        step();
        checks++;
        if (rdy0 !== 1'b1 || ffen0 !== 1'b1 || busy0 !== 1'b0 || err0 !== 1'b0) begin
            errors++; $display("FAIL b2b_done: rdy=%b ff_en=%b busy=%b err=%b want 1 1 0 0", rdy0, ffen0, busy0, err0);
        end
    endtask

    task automatic test_gapped();
        do_start();
        checks++;
        if (ffen0 !== 1'b0 || rdy0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++; $display("FAIL gap_restart: ff_en=%b rdy=%b busy=%b want 0 0 1", ffen0, rdy0, busy0);
        end
        step(); step();
        for (int k = 0; k < 4; k++) begin
            valid = 1'b0;
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (bus0.cfg_ready !== 1'b1 || cen0 !== 4'(1 << k)) begin
                    errors++; $display("FAIL gap_idle%0d_%0d: ready=%b en=%b want 1 %b", k, g, bus0.cfg_ready, cen0, 4'(1 << k));
                end
                step();
            end
            valid = 1'b1; data = words[k]; last = (k == 3);
            step();
            valid = 1'b0; last = 1'b0;
            checks++;
            if (cin0 !== words[k] || cen0 !== 4'(1 << k)) begin
                errors++; $display("FAIL gap_strobe%0d: in=%h en=%b want %h %b", k, cin0, cen0, words[k], 4'(1 << k));
            end
            if (k != 3) step();
        end
        step(); step(); step();
        checks++;
        if (ffen0 !== 1'b1 || rdy0 !== 1'b0) begin
            errors++; $display("FAIL gap_ffen: ff_en=%b rdy=%b want 1 0", ffen0, rdy0);
        end
        step(); step();
        checks++;
        if (rdy0 !== 1'b1 || err0 !== 1'b0 || cen0 !== 4'b0000) begin
            errors++; $display("FAIL gap_done: rdy=%b err=%b en=%b want 1 0 0000", rdy0, err0, cen0);
        end
    endtask

    task automatic test_partial();
        do_start();
        step(); step();
        for (int k = 0; k < 2; k++) begin
            valid = 1'b1; data = words[k]; last = (k == 1);
            step();
            step();
        end
        valid = 1'b0; last = 1'b0;
        checks++;
        if (err0 !== 1'b1 || busy0 !== 1'b0 || rdy0 !== 1'b0 || ffen0 !== 1'b0 ||
            cen0 !== 4'b0000 || bus0.cfg_ready !== 1'b0) begin
            errors++; $display("FAIL part_err0: err=%b busy=%b rdy=%b ff_en=%b en=%b ready=%b want 1 0 0 0 0000 0",
                err0, busy0, rdy0, ffen0, cen0, bus0.cfg_ready);
        end
        checks++;
        if (busy1 !== 1'b1 || err1 !== 1'b0 || cen1 !== 4'b0000) begin
            errors++; $display("FAIL part_post1: busy=%b err=%b en=%b want 1 0 0000", busy1, err1, cen1);
        end
        step(); step(); step(); step();
        checks++;
        if (rdy1 !== 1'b1 || ffen1 !== 1'b1 || err1 !== 1'b0 || cin1 !== words[1] || bus1.cfg_ready !== 1'b0) begin
            errors++; $display("FAIL part_done1: rdy=%b ff_en=%b err=%b in=%h want 1 1 0 %h", rdy1, ffen1, err1, cin1, words[1]);
        end
        checks++;
        if (err0 !== 1'b1 || rdy0 !== 1'b0) begin
            errors++; $display("FAIL part_sticky0: err=%b rdy=%b want 1 0", err0, rdy0);
        end
    endtask

    task automatic test_overflow();
        do_start();
        checks++;
        if (err0 !== 1'b0 || rdy1 !== 1'b0 || ffen1 !== 1'b0) begin
            errors++; $display("FAIL ovf_start: err0=%b rdy1=%b ff_en1=%b want 0 0 0", err0, rdy1, ffen1);
        end
        step(); step();
        for (int k = 0; k < 4; k++) begin
            valid = 1'b1; data = words[k]; last = 1'b0;
            step();
            step();
        end
        data = 16'hEEEE;
        checks++;
        if (err0 !== 1'b1 || busy0 !== 1'b0 || err1 !== 1'b1) begin
            errors++; $display("FAIL ovf_err: err0=%b busy0=%b err1=%b want 1 0 1", err0, busy0, err1);
        end
        for (int g = 0; g < 3; g++) begin
            step();
            checks++;
            if (bus0.cfg_ready !== 1'b0 || cin0 !== words[3] || cen0 !== 4'b0000) begin
                errors++; $display("FAIL ovf_hold%0d: ready=%b in=%h en=%b want 0 %h 0000", g, bus0.cfg_ready, cin0, cen0, words[3]);
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_restart();
        do_start();
        checks++;
        if (err0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++; $display("FAIL rst_start: err=%b busy=%b want 0 1", err0, busy0);
        end
        step(); step();
        for (int k = 0; k < 2; k++) begin
            valid = 1'b1; data = words[k]; last = 1'b0;
            step();
            step();
        end
        checks++;
        if (cen0 !== 4'b0100 || bus0.cfg_ready !== 1'b1) begin
            errors++; $display("FAIL rst_word3: en=%b ready=%b want 0100 1", cen0, bus0.cfg_ready);
        end
        data = words[2]; start = 1'b1;
        step();
        start = 1'b0; valid = 1'b0;
        checks++;
        if (cen0 !== 4'b0000 || bus0.cfg_ready !== 1'b0 || busy0 !== 1'b1 || cin0 !== words[1]) begin
            errors++; $display("FAIL rst_abort: en=%b ready=%b busy=%b in=%h want 0000 0 1 %h", cen0, bus0.cfg_ready, busy0, cin0, words[1]);
        end
        step(); step();
        checks++;
        if (cen0 !== 4'b0001 || bus0.cfg_ready !== 1'b1) begin
            errors++; $display("FAIL rst_reload: en=%b ready=%b want 0001 1", cen0, bus0.cfg_ready);
        end
        for (int k = 0; k < 4; k++) begin
            valid = 1'b1; data = words[k]; last = (k == 3);
            step();
            checks++;
            if (cin0 !== words[k] || cen0 !== 4'(1 << k)) begin
                errors++; $display("FAIL rst_strobe%0d: in=%h en=%b want %h %b", k, cin0, cen0, words[k], 4'(1 << k));
            end
            step();
        end
        valid = 1'b0; last = 1'b0;
        step(); step(); step(); step();
        checks++;
        if (rdy0 !== 1'b1 || err0 !== 1'b0 || ffen0 !== 1'b1) begin
            errors++; $display("FAIL rst_done: rdy=%b err=%b ff_en=%b want 1 0 1", rdy0, err0, ffen0);
        end
    endtask

    task automatic test_reset_mid_post();
        do_start();
        step(); step();
        for (int k = 0; k < 4; k++) begin
            valid = 1'b1; data = words[k]; last = (k == 3);
            step();
            step();
        end
        valid = 1'b0; last = 1'b0;
        step();
        checks++;
        if (busy0 !== 1'b1 || ffen0 !== 1'b0) begin
            errors++; $display("FAIL mid_post: busy=%b ff_en=%b want 1 0", busy0, ffen0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus0.cfg_ready, cin0, cen0, ffen0, rdy0, busy0, err0} !== '0) begin
            errors++; $display("FAIL async_reset0: in=%h en=%b ff_en=%b rdy=%b busy=%b want all zero", cin0, cen0, ffen0, rdy0, busy0);
        end
        checks++;
        if ({bus1.cfg_ready, cin1, cen1, ffen1, rdy1, busy1, err1} !== '0) begin
            errors++; $display("FAIL async_reset1: in=%h en=%b busy=%b want all zero", cin1, cen1, busy1);
        end
        #2 rst_n = 1'b1;
        for (int g = 0; g < 3; g++) begin
            step();
            checks++;
            if ({bus0.cfg_ready, cen0, ffen0, rdy0, busy0, err0} !== '0) begin
                errors++; $display("FAIL idle_after_reset%0d: ready=%b en=%b ff_en=%b rdy=%b busy=%b want all zero",
                    g, bus0.cfg_ready, cen0, ffen0, rdy0, busy0);
            end
        end
    endtask

    initial begin
        words[0] = 16'hA1A1;
        words[1] = 16'hB2B2;
        words[2] = 16'hC3C3;
        words[3] = 16'hD4D4;
        test_reset();
        test_back_to_back();
        test_gapped();
        test_partial();
        test_overflow();
        test_restart();
        test_reset_mid_post();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
